demux_1_to_4_stream_router: RTL and testbench



---
 rtl/demux_1_to_4_stream_router.sv | 93 +++++++++
 tb/tb_demux_1_to_4_stream_router.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_to_4_stream_router.sv
// Registered 1-to-4 stream router: each word goes to one of four one-entry
// output slots, chosen by select_lines or by a round-robin pointer.
module demux_1_to_4_stream_router #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       select_lines,
  input  logic             seq_mode,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data_0,
  output logic [WIDTH-1:0] out_data_1,
  output logic [WIDTH-1:0] out_data_2,
  output logic [WIDTH-1:0] out_data_3,
  output logic [1:0]       dest_ptr,
  output logic [CNT_W-1:0] cnt_0,
  output logic [CNT_W-1:0] cnt_1,
  output logic [CNT_W-1:0] cnt_2,
  output logic [CNT_W-1:0] cnt_3
);

  logic [3:0]       valid_q, valid_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [CNT_W-1:0] cnt_d  [4];
  logic [1:0]       ptr_q, ptr_d;

  logic [1:0] dest;
  logic [3:0] free;
  logic       accept;

  assign dest     = seq_mode ? ptr_q : select_lines;
  assign free     = ~valid_q | out_ready;
  assign in_ready = free[dest];
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    ptr_d   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      data_d[k] = data_q[k];
      cnt_d[k]  = cnt_q[k];
      // A drain counts even when a new word replaces the old one in the same cycle.
      if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
        cnt_d[k]   = cnt_q[k] + 1'b1;
      end
      if (accept && (dest == 2'(k))) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end
    end
    if (accept && seq_mode) begin
      ptr_d = ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 4'b0000;
      ptr_q   <= 2'b00;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  assign out_valid  = valid_q;
  assign dest_ptr   = ptr_q;
  assign out_data_0 = data_q[0];
  assign out_data_1 = data_q[1];
  assign out_data_2 = data_q[2];
  assign out_data_3 = data_q[3];
  assign cnt_0      = cnt_q[0];
  assign cnt_1      = cnt_q[1];
  assign cnt_2      = cnt_q[2];
  assign cnt_3      = cnt_q[3];

endmodule

// File: tb/tb_demux_1_to_4_stream_router.sv
// Bench for demux_1_to_4_stream_router: directed scenarios plus random traffic,
// compared every cycle against a slot-and-counter reference model.
module tb_demux_1_to_4_stream_router;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       select_lines;
  logic             seq_mode;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data_0, out_data_1, out_data_2, out_data_3;
  logic [1:0]       dest_ptr;
  logic [CNT_W-1:0] cnt_0, cnt_1, cnt_2, cnt_3;

  demux_1_to_4_stream_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .select_lines(select_lines), .seq_mode(seq_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data_0(out_data_0), .out_data_1(out_data_1),
    .out_data_2(out_data_2), .out_data_3(out_data_3),
    .dest_ptr(dest_ptr),
    .cnt_0(cnt_0), .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_3(cnt_3)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: four slots with a held word, per-slot delivery counts,
  // and a rotating pointer.
  bit   m_init = 0;
  bit   m_full [4];
  int   m_word [4];
  int   m_cnt  [4];
  int   m_ptr;
  bit   m_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_data(input int k);
    case (k)
      0: return 32'(out_data_0);
      1: return 32'(out_data_1);
      2: return 32'(out_data_2);
      default: return 32'(out_data_3);
    endcase
  endfunction

  function automatic logic [31:0] dut_cnt(input int k);
    case (k)
      0: return 32'(cnt_0);
      1: return 32'(cnt_1);
      2: return 32'(cnt_2);
      default: return 32'(cnt_3);
    endcase
  endfunction

  // Compare against the model with the current inputs, advance the model, clock once.
  task automatic tick();
    int  dst;
    bit  rdy;
    logic [3:0] vexp;
    #1;
    dst = seq_mode ? m_ptr : int'(select_lines);
    rdy = !m_full[dst] || out_ready[dst];
    if (m_init) begin
      for (int k = 0; k < 4; k++) vexp[k] = m_full[k];
      check("in_ready", 32'(in_ready), 32'(rdy));
      check("out_valid", 32'(out_valid), 32'(vexp));
      check("dest_ptr", 32'(dest_ptr), 32'(m_ptr));
      for (int k = 0; k < 4; k++) begin
        check($sformatf("out_data_%0d", k), dut_data(k), 32'(m_word[k]));
        check($sformatf("cnt_%0d", k), dut_cnt(k), 32'(m_cnt[k]));
      end
    end
    m_acc = 0;
    if (!rst_n) begin
      m_init = 1;
      m_ptr  = 0;
      for (int k = 0; k < 4; k++) begin
        m_full[k] = 0; m_word[k] = 0; m_cnt[k] = 0;
      end
    end else if (m_init) begin
      m_acc = in_valid && rdy;
      for (int k = 0; k < 4; k++) begin
        if (m_full[k] && out_ready[k]) begin
          m_full[k] = 0;
          m_cnt[k]  = (m_cnt[k] + 1) % CNT_MOD;
        end
      end
      if (m_acc) begin
        m_full[dst] = 1;
        m_word[dst] = int'(in_data);
        if (seq_mode) m_ptr = (m_ptr + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] sel, input logic mode);
    in_valid = 1'b1; in_data = d; select_lines = sel; seq_mode = mode;
    m_acc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_acc) break;
    end
    if (!m_acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    in_valid = 1'b0; seq_mode = 1'b0; select_lines = 2'b00; in_data = '0;
    rst_n = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; select_lines = 2'b00;
    seq_mode = 1'b0; out_ready = 4'hF;
    @(posedge clk);
    #1;

    // Reset and direct fan-out
    do_reset(2);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_dest_ptr", 32'(dest_ptr), 32'h0);
    check("rst_cnt_0", 32'(cnt_0), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    send(8'hA0, 2'd0, 1'b0); check("fan_d0", 32'(out_data_0), 32'hA0);
    send(8'hA1, 2'd1, 1'b0); check("fan_d1", 32'(out_data_1), 32'hA1);
    send(8'hA2, 2'd2, 1'b0); check("fan_d2", 32'(out_data_2), 32'hA2);
    send(8'hA3, 2'd3, 1'b0); check("fan_d3", 32'(out_data_3), 32'hA3);
    check("fan_v3", 32'(out_valid[3]), 32'h1);
    tick(); tick();
    check("fan_cnt", {cnt_3, cnt_2, cnt_1, cnt_0}, {4{2'd1}});

    // Backpressure on channel 2
    do_reset(1);
    out_ready = 4'b1011;
    send(8'h11, 2'd2, 1'b0);
    in_valid = 1'b1; in_data = 8'h22; select_lines = 2'd2;
    tick(); tick();
    check("bp_in_ready", 32'(in_ready), 32'h0);
    check("bp_hold", 32'(out_data_2), 32'h11);
    check("bp_ch0_idle", 32'(out_valid[0]), 32'h0);
    out_ready = 4'hF;
    tick();
    check("bp_accept", 32'(m_acc), 32'h1);
    check("bp_data2", 32'(out_data_2), 32'h22);
    check("bp_cnt2", 32'(cnt_2), 32'h1);
    in_valid = 1'b0;
    send(8'h33, 2'd0, 1'b0);
    check("bp_data0", 32'(out_data_0), 32'h33);
    tick();

    // Sequence mode wrap
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      send(8'(i + 1), 2'd3, 1'b1);
      check($sformatf("seq_word%0d", i), dut_data(i % 4), 32'(i + 1));
    end
    seq_mode = 1'b1;
    tick(); tick();
    check("seq_ptr", 32'(dest_ptr), 32'h2);
    check("seq_cnt", {cnt_3, cnt_2, cnt_1, cnt_0}, {2'd1, 2'd1, 2'd2, 2'd2});

    // Same-channel replace
    do_reset(1);
    send(8'h55, 2'd1, 1'b0);
    send(8'h66, 2'd1, 1'b0);
    check("rep_valid", 32'(out_valid[1]), 32'h1);
    check("rep_data", 32'(out_data_1), 32'h66);
    check("rep_cnt", 32'(cnt_1), 32'h1);
    tick();
    check("rep_cnt2", 32'(cnt_1), 32'h2);

    // Reset mid-operation
    do_reset(1);
    out_ready = 4'h0;
    send(8'hC0, 2'd0, 1'b1);
    send(8'hC1, 2'd0, 1'b1);
    send(8'hC2, 2'd0, 1'b1);
    send(8'hC3, 2'd3, 1'b0);
    check("mid_full", 32'(out_valid), 32'hF);
    check("mid_ptr", 32'(dest_ptr), 32'h3);
    do_reset(1);
    #1;
    check("mid_valid", 32'(out_valid), 32'h0);
    check("mid_data", {out_data_3, out_data_2, out_data_1, out_data_0}, 32'h0);
    check("mid_cnt", {cnt_3, cnt_2, cnt_1, cnt_0}, 32'h0);
    check("mid_ptr0", 32'(dest_ptr), 32'h0);

    // Counter wrap
    out_ready = 4'hF;
    for (int i = 0; i < 5; i++) send(8'(8'hE0 + i), 2'd3, 1'b0);
    tick();
    check("wrap_cnt3", 32'(cnt_3), 32'h1);

    // Random traffic, with occasional resets
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if (!in_valid || m_acc) begin
        in_valid     = ($urandom_range(0, 3) != 0);
        in_data      = 8'($urandom);
        select_lines = 2'($urandom);
      end
      if ($urandom_range(0, 15) == 0) seq_mode = ~seq_mode;
      out_ready = 4'($urandom);
      tick();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
